// File: rtl/bist_checker_if.sv
// Generator-to-checker bus for the deterministic pattern generators.
// The generator drives the master modport and the checker uses the slave modport.
//   pg_en    : advance enable, checker -> generator
//   pg_rst   : generator reset, checker -> generator
//   pg_addr  : access address
//   pg_data  : write data
//   pg_check : expected read data
//   pg_wmask : write mask
//   pg_we    : write strobe
//   pg_re    : read strobe
//   pg_done  : generator has finished its sequence
interface bist_checker_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 4
);
  logic                  pg_en;
  logic                  pg_rst;
  logic [ADDR_WIDTH-1:0] pg_addr;
  logic [DATA_WIDTH-1:0] pg_data;
  logic [DATA_WIDTH-1:0] pg_check;
  logic [MASK_WIDTH-1:0] pg_wmask;
  logic                  pg_we;
  logic                  pg_re;
  logic                  pg_done;

  modport master (
    input  pg_en,
    input  pg_rst,
    output pg_addr,
    output pg_data,
    output pg_check,
    output pg_wmask,
    output pg_we,
    output pg_re,
    output pg_done
  );

  modport slave (
    output pg_en,
    output pg_rst,
    input  pg_addr,
    input  pg_data,
    input  pg_check,
    input  pg_wmask,
    input  pg_we,
    input  pg_re,
    input  pg_done
  );
endinterface

// File: rtl/bist_checker.sv
// SRAM BIST checker. Sequences a deterministic pattern generator, drives the SRAM port from
// its outputs, delays the expected read data by the SRAM read latency, compares read data,
// counts mismatches (saturating) and captures the first failure.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   i_en                 : run enable from the test controller, low pauses the test
//   pg                   : generator bus (slave side)
//   o_sram_*             : SRAM macro port (ce, we, addr, din, wmask)
//   i_sram_dout          : SRAM read data, valid READ_LATENCY cycles after a read
//   o_done, o_pass       : test complete / complete with zero errors
//   o_err_count          : saturating mismatch count
//   o_fail_valid/addr/expected/actual : first failure capture
module bist_checker #(
  parameter int unsigned MAX_ADDR      = 255,
  parameter int unsigned ADDR_WIDTH    = $clog2(MAX_ADDR),
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MASK_WIDTH    = 4,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  bist_checker_if.slave            pg,
  output logic                     o_sram_ce,
  output logic                     o_sram_we,
  output logic [ADDR_WIDTH-1:0]    o_sram_addr,
  output logic [DATA_WIDTH-1:0]    o_sram_din,
  output logic [MASK_WIDTH-1:0]    o_sram_wmask,
  input  logic [DATA_WIDTH-1:0]    i_sram_dout,
  output logic                     o_done,
  output logic                     o_pass,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count,
  output logic                     o_fail_valid,
  output logic [ADDR_WIDTH-1:0]    o_fail_addr,
  output logic [DATA_WIDTH-1:0]    o_fail_expected,
  output logic [DATA_WIDTH-1:0]    o_fail_actual
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [2:0] DrainLast = 3'(READ_LATENCY - 1);

  state_e r_state;
  state_e w_state_d;
  logic [2:0] r_drain_cnt;

  logic w_access;
  logic w_read_issue;

  // Check pipeline; stage READ_LATENCY-1 lines up with i_sram_dout.
  logic                  r_pipe_valid [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] r_pipe_addr  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] r_pipe_check [READ_LATENCY];

  logic                     w_cmp_valid;
  logic                     w_mismatch;
  logic [ERR_CNT_WIDTH-1:0] w_err_count_d;

  logic                     r_done;
  logic                     r_pass;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;
  logic                     r_fail_valid;
  logic [ADDR_WIDTH-1:0]    r_fail_addr;
  logic [DATA_WIDTH-1:0]    r_fail_expected;
  logic [DATA_WIDTH-1:0]    r_fail_actual;

  // ---------------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain_cnt <= '0;
    end else if (r_state == StDrain) begin
      r_drain_cnt <= r_drain_cnt + 3'd1;
    end else begin
      r_drain_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_en) w_state_d = StRun;
      StRun:   if (pg.pg_done) w_state_d = StDrain;
      // Wait out the reads still in flight before declaring the result.
      StDrain: if (r_drain_cnt == DrainLast) w_state_d = StDone;
      StDone:  w_state_d = StDone;
      default: w_state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    pg.pg_rst    = rst;
    pg.pg_en     = (r_state == StRun) && i_en;
    // pg_done gates a coincident access so nothing is issued once the sequence is over.
    w_access     = (r_state == StRun) && i_en && !pg.pg_done;
    w_read_issue = w_access && pg.pg_re;
    o_sram_ce    = w_access && (pg.pg_we || pg.pg_re);
    o_sram_we    = w_access && pg.pg_we;
    o_sram_addr  = pg.pg_addr;
    o_sram_din   = pg.pg_data;
    o_sram_wmask = pg.pg_wmask;
  end

  // ---------------------------------------------------------------------------------------------
  // Check pipeline: advances every cycle regardless of i_en so in-flight reads complete.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        r_pipe_valid[i] <= 1'b0;
        r_pipe_addr[i]  <= '0;
        r_pipe_check[i] <= '0;
      end
    end else begin
      r_pipe_valid[0] <= w_read_issue;
      r_pipe_addr[0]  <= pg.pg_addr;
      r_pipe_check[0] <= pg.pg_check;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_addr[i]  <= r_pipe_addr[i-1];
        r_pipe_check[i] <= r_pipe_check[i-1];
      end
    end
  end

  // Full-word compare; the write mask has no meaning for reads.
  always_comb begin
    w_cmp_valid   = r_pipe_valid[READ_LATENCY-1];
    w_mismatch    = w_cmp_valid && (i_sram_dout != r_pipe_check[READ_LATENCY-1]);
    w_err_count_d = r_err_count;
    if (w_mismatch && (r_err_count != '1)) begin
      w_err_count_d = r_err_count + ERR_CNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count     <= '0;
      r_fail_valid    <= 1'b0;
      r_fail_addr     <= '0;
      r_fail_expected <= '0;
      r_fail_actual   <= '0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
    end else begin
      r_err_count <= w_err_count_d;
      // Only the first failure is kept for scan-out.
      if (w_mismatch && !r_fail_valid) begin
        r_fail_valid    <= 1'b1;
        r_fail_addr     <= r_pipe_addr[READ_LATENCY-1];
        r_fail_expected <= r_pipe_check[READ_LATENCY-1];
        r_fail_actual   <= i_sram_dout;
      end
      r_done <= (w_state_d == StDone);
      r_pass <= (w_state_d == StDone) && (w_err_count_d == '0);
    end
  end

  assign o_done          = r_done;
  assign o_pass          = r_pass;
  assign o_err_count     = r_err_count;
  assign o_fail_valid    = r_fail_valid;
  assign o_fail_addr     = r_fail_addr;
  assign o_fail_expected = r_fail_expected;
  assign o_fail_actual   = r_fail_actual;

  // ---------------------------------------------------------------------------------------------
  // Properties
  // ---------------------------------------------------------------------------------------------
  a_we_implies_ce : assert property (@(posedge clk) o_sram_we |-> o_sram_ce);
  a_no_we_and_re  : assert property (@(posedge clk) disable iff (rst)
                                     !(pg.pg_we && pg.pg_re));
  a_err_monotonic : assert property (@(posedge clk) !rst |=> (o_err_count >= $past(o_err_count)));
  a_addr_in_range : assert property (@(posedge clk) disable iff (rst)
                                     w_access |-> (32'(pg.pg_addr) <= MAX_ADDR));

endmodule
